// File: rtl/if_id_skid_buffer_pkg.sv
// rtl/if_id_skid_buffer_pkg.sv - shared widths, NOP constant and state encoding for the IF/ID skid buffer
package if_id_skid_buffer_pkg;

    localparam int          IF_ID_DATA_W    = 32;
    localparam logic [31:0] IF_ID_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// rtl/if_id_skid_buffer_if.sv - fetch-side and decode-side handshake bundle for the IF/ID boundary
interface if_id_skid_buffer_if
    import if_id_skid_buffer_pkg::*;
#(
    parameter int DATA_W = IF_ID_DATA_W
);
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] InPCPlus4;
    logic [DATA_W-1:0] InInstruction;
    logic              Flush;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutPCPlus4;
    logic [DATA_W-1:0] OutInstruction;

    modport slave (
        input  InValid, InPCPlus4, InInstruction, Flush, OutReady,
        output InReady, OutValid, OutPCPlus4, OutInstruction
    );

    modport master (
        output InValid, InPCPlus4, InInstruction, Flush, OutReady,
        input  InReady, OutValid, OutPCPlus4, OutInstruction
    );
endinterface

// File: rtl/if_id_entry_reg.sv
// rtl/if_id_entry_reg.sv - one {valid, PC+4, instruction} slot with load enable and synchronous clear
module if_id_entry_reg #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    // Clear wins over load so a flush can never leave a stale valid bit behind.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end
endmodule

// File: rtl/if_id_skid_buffer.sv
// rtl/if_id_skid_buffer.sv - 2-entry IF/ID skid buffer with registered back-pressure and flush
module if_id_skid_buffer
    import if_id_skid_buffer_pkg::*;
#(
    parameter int              DATA_W    = IF_ID_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IF_ID_NOP_INSTR)
) (
    input logic                 Clk,
    input logic                 Reset,
    if_id_skid_buffer_if.slave  bus
);
    localparam int EW = 2 * DATA_W + 1;

    logic [EW-1:0] main_q;
    logic [EW-1:0] skid_q;
    logic [EW-1:0] main_d;
    logic [EW-1:0] in_entry;
    logic          main_v;
    logic          skid_v;
    logic          main_load;
    logic          skid_load;
    logic          main_clr;
    logic          skid_clr;
    logic          accept;
    logic          consume;
    if_id_state_e  state;
    if_id_state_e  st_next;

    assign main_v   = main_q[EW-1];
    assign skid_v   = skid_q[EW-1];
    assign in_entry = {1'b1, bus.InPCPlus4, bus.InInstruction};
    assign accept   = bus.InValid & ~skid_v;
    assign consume  = main_v & bus.OutReady;

    // The state lives in the two valid bits; this just names it.
    always_comb begin
        case ({skid_v, main_v})
            2'b00:   state = ST_EMPTY;
            2'b01:   state = ST_ONE;
            default: state = ST_TWO;
        endcase
    end

    always_comb begin
        st_next   = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_entry;
        if (bus.Flush) begin
            st_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        st_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        st_next   = ST_TWO;
                    end else if (consume) begin
                        st_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_load = 1'b1;
                        main_d    = skid_q;
                        st_next   = ST_ONE;
                    end
                end
                default: st_next = ST_EMPTY;
            endcase
        end
    end

    // Slots that are not occupied in the next state are zeroed.
    assign main_clr = (st_next == ST_EMPTY);
    assign skid_clr = (st_next != ST_TWO);

    if_id_entry_reg #(.W(EW)) u_main (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (main_clr),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    if_id_entry_reg #(.W(EW)) u_skid (
        .clk  (Clk),
        .rst  (Reset),
        .clr  (skid_clr),
        .load (skid_load),
        .d    (in_entry),
        .q    (skid_q)
    );

    assign bus.InReady        = ~skid_v;
    assign bus.OutValid       = main_v;
    assign bus.OutPCPlus4     = main_v ? main_q[EW-2 -: DATA_W] : '0;
    assign bus.OutInstruction = main_v ? main_q[DATA_W-1:0] : NOP_INSTR;
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb/tb_if_id_skid_buffer.sv - scoreboard bench for the IF/ID skid buffer
module tb_if_id_skid_buffer;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] sb[$];
    logic [31:0] log_q[$];
    logic [63:0] mon_exp;
    bit          seen_ff = 1'b0;

    if_id_skid_buffer_if #(.DATA_W(32)) bus ();

    if_id_skid_buffer #(.DATA_W(32), .NOP_INSTR(NOP)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: pop on consume, push on accept, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.OutValid && bus.OutInstruction == 32'hFFFF_FFFF) seen_ff = 1'b1;
            if (bus.OutValid && bus.OutReady) begin
                log_q.push_back(bus.OutInstruction);
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got pc=%h instr=%h with nothing expected",
                             bus.OutPCPlus4, bus.OutInstruction);
                end else begin
                    mon_exp = sb.pop_front();
                    if ({bus.OutPCPlus4, bus.OutInstruction} !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_data: got %h_%h expected %h_%h",
                                 bus.OutPCPlus4, bus.OutInstruction, mon_exp[63:32], mon_exp[31:0]);
                    end
                end
            end
            if (bus.Flush) sb.delete();
            else if (bus.InValid && bus.InReady) sb.push_back({bus.InPCPlus4, bus.InInstruction});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        bus.InValid       = v;
        bus.InPCPlus4     = pc;
        bus.InInstruction = ins;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries left, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Flush = 1'b0;
        bus.OutReady = 1'b0;
        drive(1'b1, 32'h4, 32'h8C08_0004);
        step();
        step();
        checks++;
        if (bus.OutValid !== 1'b0 || bus.OutInstruction !== NOP || bus.OutPCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b instr=%h pc=%h expected 0/%h/0",
                     bus.OutValid, bus.OutInstruction, bus.OutPCPlus4, NOP);
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        checks++;
        if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", bus.InReady, bus.OutValid);
        end
    endtask

    task automatic test_stream();
        bus.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * (i + 1)), 32'h1000_0000 + 32'(i));
            step();
            checks++;
            if (bus.OutValid !== 1'b1 || bus.OutPCPlus4 !== 32'(4 * (i + 1)) || bus.InReady !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: valid=%b pc=%h ready=%b expected 1/%h/1",
                         i, bus.OutValid, bus.OutPCPlus4, bus.InReady, 32'(4 * (i + 1)));
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        wait_drain("stream");
    endtask

    task automatic test_back_to_back();
        bus.OutReady = 1'b0;
        log_q.delete();
        drive(1'b1, 32'h40, 32'h2009_0001);
        step();
        drive(1'b1, 32'h44, 32'h200A_0002);
        step();
        checks++;
        if (bus.InReady !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_low: in_ready=%b expected 0", bus.InReady);
        end
        drive(1'b1, 32'h48, 32'h200B_0003);
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.InReady !== 1'b0 || bus.OutInstruction !== 32'h2009_0001) begin
            errors++;
            $display("FAIL bp_hold: ready=%b instr=%h expected 0/20090001", bus.InReady, bus.OutInstruction);
        end
        bus.OutReady = 1'b1;
        step();
        checks++;
        if (bus.InReady !== 1'b1 || bus.OutInstruction !== 32'h200A_0002) begin
            errors++;
            $display("FAIL bp_release: ready=%b instr=%h expected 1/200a0002", bus.InReady, bus.OutInstruction);
        end
        step();
        drive(1'b0, 32'h0, 32'h0);
        wait_drain("bp");
        checks++;
        if (log_q.size() != 3 || log_q[0] !== 32'h2009_0001 || log_q[1] !== 32'h200A_0002
            || log_q[2] !== 32'h200B_0003) begin
            errors++;
            $display("FAIL bp_order: got %0d words, expected 20090001,200a0002,200b0003", log_q.size());
        end
    endtask

    task automatic test_flush();
        bus.OutReady = 1'b0;
        drive(1'b1, 32'h50, 32'h2222_0001);
        step();
        drive(1'b1, 32'h54, 32'h2222_0002);
        step();
        bus.Flush = 1'b1;
        drive(1'b1, 32'h58, 32'hFFFF_FFFF);
        step();
        bus.Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b0 || bus.OutInstruction !== NOP || bus.InReady !== 1'b1
            || bus.OutPCPlus4 !== 32'h0) begin
            errors++;
            $display("FAIL flush_state: valid=%b instr=%h ready=%b pc=%h expected 0/%h/1/0",
                     bus.OutValid, bus.OutInstruction, bus.InReady, bus.OutPCPlus4, NOP);
        end
        bus.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (seen_ff !== 1'b0 || bus.OutValid !== 1'b0) begin
            errors++;
            $display("FAIL flush_leak: seen_ff=%b valid=%b expected 0/0", seen_ff, bus.OutValid);
        end
    endtask

    task automatic test_accept_consume();
        bus.OutReady = 1'b1;
        drive(1'b1, 32'h20, 32'h3000_0020);
        step();
        drive(1'b1, 32'h24, 32'h3000_0024);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutPCPlus4 !== 32'h24 || bus.InReady !== 1'b1) begin
            errors++;
            $display("FAIL one_acc_cons: valid=%b pc=%h ready=%b expected 1/00000024/1",
                     bus.OutValid, bus.OutPCPlus4, bus.InReady);
        end
        wait_drain("one");
    endtask

    task automatic test_reset_mid();
        bus.OutReady = 1'b0;
        drive(1'b1, 32'h60, 32'h4444_0001);
        step();
        drive(1'b1, 32'h64, 32'h4444_0002);
        step();
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.OutValid !== 1'b0 || bus.OutInstruction !== NOP || bus.InReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_state: valid=%b instr=%h ready=%b expected 0/%h/1",
                     bus.OutValid, bus.OutInstruction, bus.InReady, NOP);
        end
        bus.OutReady = 1'b1;
        drive(1'b1, 32'h28, 32'h0000_0027);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++;
        if (bus.OutValid !== 1'b1 || bus.OutInstruction !== 32'h0000_0027) begin
            errors++;
            $display("FAIL rst_mid_word: valid=%b instr=%h expected 1/00000027", bus.OutValid, bus.OutInstruction);
        end
        step();
        checks++;
        if (bus.OutValid !== 1'b0 || bus.OutInstruction !== NOP) begin
            errors++;
            $display("FAIL rst_mid_alone: valid=%b instr=%h expected 0/%h", bus.OutValid, bus.OutInstruction, NOP);
        end
        wait_drain("rst_mid");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_accept_consume();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
